// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder / imem loader: range-checks the immediate, packs R/D/CB
// words and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [10:0]       in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [5:0]        in_shamt,
    input  logic [63:0]       in_imm,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, full_q, full_d, err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              legal;
    logic [31:0]       word;

    // Immediate fits when every bit above the field's sign bit matches it.
    always_comb begin
        legal = 1'b0;
        word  = '0;
        unique case (in_fmt)
            2'b00: begin
                legal = 1'b1;
                word  = {in_op, in_rm, in_shamt, in_rn, in_rd};
            end
            2'b01: begin
                legal = (&in_imm[63:8]) | ~(|in_imm[63:8]);
                word  = {in_op, in_imm[8:0], 2'b00, in_rn, in_rd};
            end
            2'b10: begin
                legal = (&in_imm[63:18]) | ~(|in_imm[63:18]);
                word  = {in_op[10:3], in_imm[18:0], in_rd};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        full_d    = full_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    ptr_d     = '0;
                    full_d    = 1'b0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (legal) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = word;
                        ptr_d     = ptr_q + 1'b1;
                        if (ptr_q == {ADDR_W{1'b1}}) begin
                            full_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (in_last) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            full_q    <= full_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign full      = full_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder against an arithmetic reference model.
module tb_instr_encoder;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [1:0]        in_fmt = '0;
    logic [10:0]       in_op = '0;
    logic [4:0]        in_rd = '0, in_rn = '0, in_rm = '0;
    logic [5:0]        in_shamt = '0;
    logic [63:0]       in_imm = '0;
    logic              in_ready, wr_en, busy, done, full, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [7:0]        err_count;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_last(in_last), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .full(full),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];

    int vectors = 0, miscompares = 0;
    // Reference state: 0 idle, 1 loading, 2 finished.
    int m_st = 0, m_ptr = 0, m_cnt = 0, hold_a = 0;
    bit m_full = 0, m_err = 0;
    logic [31:0] hold_d = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] encode(input int fmt, input longint unsigned op,
        input longint unsigned rd, input longint unsigned rn, input longint unsigned rm,
        input longint unsigned sh, input longint imm, output bit ok);
        longint unsigned u, w;
        u = longint'(imm);
        w = 0;
        ok = 0;
        case (fmt)
            0: begin ok = 1; w = op * 2097152 + rm * 65536 + sh * 1024 + rn * 32 + rd; end
            1: begin ok = (imm >= -256 && imm <= 255);
                     w = op * 2097152 + (u % 512) * 4096 + rn * 32 + rd; end
            2: begin ok = (imm >= -262144 && imm <= 262143);
                     w = (op / 8) * 16777216 + (u % 524288) * 32 + rd; end
            default: ok = 0;
        endcase
        return w[31:0];
    endfunction

    // One clock: check status before the edge, then advance the model at the edge.
    task automatic step();
        bit ok;
        logic [31:0] w;
        @(negedge clk);
        chk("in_ready", in_ready, m_st == 1);
        chk("busy", busy, m_st == 1);
        chk("done", done, m_st == 2);
        chk("full", full, m_full);
        chk("err", err, m_err);
        chk("err_count", err_count, m_cnt);
        @(posedge clk);
        if (reset) begin
            m_st = 0; m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0;
            hold_a = 0; hold_d = '0;
            exp_q.delete();
        end else if (m_st != 1) begin
            if (start) begin
                m_st = 1; m_ptr = 0; m_full = 0; m_err = 0; m_cnt = 0;
            end
        end else if (in_valid) begin
            w = encode(int'(in_fmt), in_op, in_rd, in_rn, in_rm, in_shamt, in_imm, ok);
            if (ok) begin
                exp_q.push_back('{m_ptr, w});
                hold_a = m_ptr; hold_d = w;
                if (m_ptr == DEPTH - 1) begin m_full = 1; m_st = 2; end
                m_ptr = (m_ptr + 1) % DEPTH;
            end else begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (in_last) m_st = 2;
        end
        #1;
    endtask

    // Monitor: each expected write must show up exactly one cycle after its transfer.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end else begin
            if (exp_q.size() != 0) begin
                chk("missing_write", 0, 1);
                void'(exp_q.pop_front());
            end
            chk("hold_addr", wr_addr, hold_a);
            chk("hold_data", wr_data, hold_d);
        end
    end

    task automatic xfer(input logic [1:0] f, input logic [10:0] op, input logic [4:0] rd,
        input logic [4:0] rn, input logic [4:0] rm, input logic [5:0] sh,
        input longint imm, input logic last);
        in_valid = 1; in_fmt = f; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
        in_shamt = sh; in_imm = imm; in_last = last;
        step();
        in_valid = 0; in_last = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    function automatic longint rand_imm();
        longint b[8] = '{-256, 255, 256, -257, -262144, 262143, 262144, -262145};
        case ($urandom_range(0, 3))
            0: return b[$urandom_range(0, 7)];
            1: return longint'(int'($urandom_range(0, 600)) - 300);
            2: return longint'(int'($urandom_range(0, 540000)) - 270000);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        step(); step();
        reset = 0;
        step();
        // Directed session from the worked examples.
        pulse_start();
        xfer(2'b01, 11'b111_1100_0010, 5'd22, 5'd9, 5'd0, 6'd0, 227, 0);
        xfer(2'b01, 11'b111_1100_0010, 5'd22, 5'd9, 5'd0, 6'd0, -29, 0);
        xfer(2'b01, 11'b111_1100_0010, 5'd22, 5'd9, 5'd0, 6'd0, 256, 0);
        xfer(2'b10, 11'b1011_0100_000, 5'd22, 5'd0, 5'd0, 6'd0, 64'h1E3FA, 0);
        xfer(2'b10, 11'b1011_0100_000, 5'd22, 5'd0, 5'd0, 6'd0, -262145, 0);
        xfer(2'b11, 11'h7FF, 5'd1, 5'd2, 5'd3, 6'd4, 0, 0);
        xfer(2'b00, 11'b100_0101_1000, 5'd9, 5'd20, 5'd21, 6'd0, -1, 1);
        xfer(2'b00, 11'h123, 5'd1, 5'd1, 5'd1, 6'd1, 0, 0);
        pulse_start();
        xfer(2'b01, 11'h7C0, 5'd3, 5'd4, 5'd0, 6'd0, -256, 0);
        xfer(2'b01, 11'h7C0, 5'd3, 5'd4, 5'd0, 6'd0, 255, 1);
        step();
        // Random traffic, including ignored starts while loading and rejected transfers.
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_fmt   = 2'($urandom_range(0, 3));
            in_op    = 11'($urandom);
            in_rd    = 5'($urandom); in_rn = 5'($urandom); in_rm = 5'($urandom);
            in_shamt = 6'($urandom);
            in_imm   = rand_imm();
            in_last  = ($urandom_range(0, 24) == 0);
            step();
        end
        start = 0; in_valid = 0; in_last = 0;
        step();
        // Capacity: back-to-back legal transfers until the memory fills.
        pulse_start();
        for (int i = 0; i < DEPTH + 4; i++) begin
            in_valid = 1; in_fmt = 2'b01; in_op = 11'($urandom);
            in_rd = 5'($urandom); in_rn = 5'($urandom);
            in_imm = longint'(int'($urandom_range(0, 511)) - 256);
            step();
        end
        in_valid = 0;
        step();
        // Reset in the middle of a session.
        pulse_start();
        xfer(2'b00, 11'h456, 5'd7, 5'd8, 5'd9, 6'd10, 0, 0);
        xfer(2'b01, 11'h7C2, 5'd5, 5'd6, 5'd0, 6'd0, 17, 0);
        reset = 1; start = 1;
        step();
        reset = 0; start = 0;
        step();
        pulse_start();
        xfer(2'b10, 11'h5A0, 5'd2, 5'd0, 5'd0, 6'd0, -5, 0);
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
